// File: rtl/cic3_sdm_decimator.sv
// cic3_sdm_decimator
// Second-order sigma-delta modulator model feeding a third-order CIC (sinc3)
// decimator. Everything runs on clk; the decimated output rate is marked by
// a one-cycle strobe instead of a divided clock. The modulator is a
// behavioural model built on real-valued state so the analog stimulus can be
// driven straight into the front end.
module cic3_sdm_decimator #(
  parameter int DECIMATION_FACTOR = 256,
  parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
  parameter int NUMBITS           = 3 * CLOCK_WIDTH + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  real                analog_in,
  input  logic               bit_sel,
  input  logic               bit_in,
  output logic               mod_out,
  output logic [NUMBITS-1:0] out,
  output logic               out_valid
);

  // Inputs beyond this magnitude push the loop toward instability.
  localparam real CLAMP_LEVEL = 0.9;

  // Last count of a decimation frame; the strobe fires on this cycle.
  localparam logic [CLOCK_WIDTH-1:0] LAST_COUNT = CLOCK_WIDTH'(DECIMATION_FACTOR - 1);

  // Modulator state and its next-state values.
  real x1;
  real x2;
  real u;
  real v;
  real x1_next;
  real x2_next;

  // CIC datapath. Every stage is NUMBITS wide, and wrap-around is intended:
  // the comb differences cancel the integrator overflow exactly.
  logic                   cic_bit;
  logic [NUMBITS-1:0]     cic_in;
  logic [NUMBITS-1:0]     a1;
  logic [NUMBITS-1:0]     a2;
  logic [NUMBITS-1:0]     a3;
  logic [NUMBITS-1:0]     d1;
  logic [NUMBITS-1:0]     d2;
  logic [NUMBITS-1:0]     d3;
  logic [NUMBITS-1:0]     c1;
  logic [NUMBITS-1:0]     c2;
  logic [NUMBITS-1:0]     c3;
  logic [CLOCK_WIDTH-1:0] count;
  logic                   strobe;

  // Limit the analog input to the range where the loop stays well behaved.
  always_comb begin
    u = analog_in;
    if (analog_in > CLAMP_LEVEL) begin
      u = CLAMP_LEVEL;
    end else if (analog_in < -CLAMP_LEVEL) begin
      u = -CLAMP_LEVEL;
    end
  end

  // The 1-bit quantiser looks at the second integrator. Zero counts as
  // positive, so the output is high while the state is cleared.
  assign mod_out = (x2 >= 0.0);

  // Work out the feedback level and the next integrator values. The second
  // integrator takes the first integrator's new value, not its old one.
  always_comb begin
    v       = mod_out ? 1.0 : -1.0;
    x1_next = x1 + u - v;
    x2_next = x2 + x1_next - v;
  end

  // Modulator integrator registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x1 <= 0.0;
      x2 <= 0.0;
    end else begin
      x1 <= x1_next;
      x2 <= x2_next;
    end
  end

  // Choose the CIC input. The bit is treated as an unsigned 0/1 value.
  assign cic_bit = bit_sel ? bit_in : mod_out;
  assign cic_in  = {{(NUMBITS-1){1'b0}}, cic_bit};

  // Three cascaded integrators at the full clock rate. Each stage adds the
  // previous stage's registered value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a1 <= '0;
      a2 <= '0;
      a3 <= '0;
    end else begin
      a1 <= a1 + cic_in;
      a2 <= a2 + a1;
      a3 <= a3 + a2;
    end
  end

  // Decimation counter. Because R is a power of two, the counter wraps on
  // its own after R-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count + CLOCK_WIDTH'(1);
    end
  end

  assign strobe = (count == LAST_COUNT);

  // Comb differences at the decimated rate. Only their values on the strobe
  // cycle are used.
  always_comb begin
    c1 = a3 - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
  end

  // Comb delay registers. They advance once per decimation frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (strobe) begin
      d1 <= a3;
      d2 <= c1;
      d3 <= c2;
    end
  end

  // Registered output word and its single-cycle valid pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= strobe;
      if (strobe) begin
        out <= c3;
      end
    end
  end

endmodule

// File: tb/tb_cic3_sdm_decimator.sv
// tb_cic3_sdm_decimator
// Scoreboard bench for the sigma-delta + sinc3 decimator. Each stimulus phase
// pushes the values it expects for the upcoming output pulses. A monitor pops
// one entry per out_valid and also checks the spacing between pulses.
module tb_cic3_sdm_decimator;

  localparam int     DECIMATION_FACTOR = 256;
  localparam int     CLOCK_WIDTH       = 8;
  localparam int     NUMBITS           = 25;
  localparam longint FULL_SCALE        = 64'sd16777216;
  localparam longint HALF_SCALE        = 64'sd8388608;
  localparam longint ANALOG_TOL        = 64'sd83886;

  typedef struct packed {
    logic               check;
    logic signed [63:0] expected;
    logic signed [63:0] tol;
  } expect_t;

  logic               clk = 1'b0;
  logic               reset_n;
  real                analog_in;
  logic               bit_sel;
  logic               bit_in;
  logic               mod_out;
  logic [NUMBITS-1:0] out;
  logic               out_valid;

  int      check_count = 0;
  int      fail_count  = 0;
  int      pattern     = 1;
  int      edge_count  = 0;
  int      last_pulse  = 0;
  string   current_tag = "init";
  expect_t exp_q[$];
  expect_t mon_entry;

  cic3_sdm_decimator #(
    .DECIMATION_FACTOR(DECIMATION_FACTOR),
    .CLOCK_WIDTH(CLOCK_WIDTH),
    .NUMBITS(NUMBITS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .analog_in(analog_in),
    .bit_sel(bit_sel),
    .bit_in(bit_in),
    .mod_out(mod_out),
    .out(out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Compare one observed value with the expected value, allowing an
  // optional tolerance, and record the result.
  task automatic check_output(input string tag, input longint observed,
                              input longint expected, input longint tol = 0);
    longint diff;
    check_count++;
    diff = observed - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (tolerance %0d)",
               tag, observed, expected, tol);
    end
  endtask

  // Drive the external bitstream on falling edges: 0 = zeros, 1 = ones,
  // 2 = toggle every clock.
  initial begin
    bit_in = 1'b0;
    forever begin
      @(negedge clk);
      case (pattern)
        0:       bit_in = 1'b0;
        1:       bit_in = 1'b1;
        default: bit_in = ~bit_in;
      endcase
    end
  end

  // Count rising edges since the last reset release, for pulse spacing.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_count <= 0;
    else          edge_count <= edge_count + 1;
  end

  // Monitor: on each output pulse, check the spacing and compare against the
  // scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_pulse = 0;
    end else if (out_valid) begin
      check_output("pulse_gap", longint'(edge_count - last_pulse), longint'(DECIMATION_FACTOR));
      last_pulse = edge_count;
      check_output("pulse_expected", longint'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_entry = exp_q.pop_front();
        if (mon_entry.check) begin
          check_output(current_tag, longint'(out), mon_entry.expected, mon_entry.tol);
        end
      end
    end
  end

  // Assert reset away from the clock edge. Check that the reset values
  // appear at once and hold, then release on a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("reset_out", longint'(out), 0);
    check_output("reset_valid", longint'(out_valid), 0);
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_hold_mod_out", longint'(mod_out), 1);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Set up a phase. Queue n_skip unchecked settling pulses followed by
  // n_check pulses that must match, then restart the DUT from reset.
  task automatic apply_stimulus(input string tag, input logic sel, input int pat,
                                input real level, input int n_skip, input int n_check,
                                input longint expected, input longint tol);
    expect_t e;
    bit_sel     = sel;
    pattern     = pat;
    analog_in   = level;
    current_tag = tag;
    for (int i = 0; i < n_skip + n_check; i++) begin
      e.check    = (i >= n_skip);
      e.expected = expected;
      e.tol      = tol;
      exp_q.push_back(e);
    end
    apply_reset();
  endtask

  // Wait, within a cycle budget, until every queued pulse has been seen.
  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_output({current_tag, "_drain"}, longint'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  // Hard time limit in case a wait never ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d", check_count);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int     ones;
    expect_t e;
    reset_n   = 1'b0;
    bit_sel   = 1'b1;
    analog_in = 0.0;

    // All-ones input settles at full scale R^3 and stays there despite the
    // integrators wrapping.
    apply_stimulus("ones", 1'b1, 1, 0.0, 3, 5, FULL_SCALE, 0);
    wait_drain(9 * DECIMATION_FACTOR);

    // All-zeros input is exactly zero on every pulse, transients included.
    apply_stimulus("zeros", 1'b1, 0, 0.0, 0, 6, 0, 0);
    wait_drain(7 * DECIMATION_FACTOR);

    // An alternating 1,0 stream averages to exactly half scale.
    apply_stimulus("alternate", 1'b1, 2, 0.0, 3, 5, HALF_SCALE, 0);
    wait_drain(9 * DECIMATION_FACTOR);

    // Modulator with zero input: ones-density of 0.5 and a half-scale output.
    apply_stimulus("analog_zero", 1'b0, 0, 0.0, 3, 13, HALF_SCALE, 84000);
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (mod_out) ones++;
    end
    check_output("density_zero", longint'(ones), 2048, 4);
    wait_drain(17 * DECIMATION_FACTOR);

    // Modulator at +0.5: output should be 0.75 of full scale.
    apply_stimulus("analog_half", 1'b0, 0, 0.5, 3, 5, 64'sd12582912, ANALOG_TOL);
    wait_drain(9 * DECIMATION_FACTOR);

    // Input far over range is clamped to +0.9, which gives 0.95 of full scale.
    apply_stimulus("analog_clamp", 1'b0, 0, 3.0, 3, 5, 64'sd15938355, ANALOG_TOL);
    wait_drain(9 * DECIMATION_FACTOR);

    // Reset in the middle of a frame clears the output at once, and the
    // frame timing restarts from the release.
    apply_stimulus("midframe_pre", 1'b1, 1, 0.0, 2, 0, 0, 0);
    repeat (2 * DECIMATION_FACTOR + 100) @(posedge clk);
    wait_drain(DECIMATION_FACTOR);
    #3;
    check_output("midframe_out_before", longint'(out != '0), 1);
    reset_n = 1'b0;
    #1;
    check_output("midframe_out_cleared", longint'(out), 0);
    check_output("midframe_valid_cleared", longint'(out_valid), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    current_tag = "midframe_post";
    for (int i = 0; i < 5; i++) begin
      e.check    = (i >= 3);
      e.expected = FULL_SCALE;
      e.tol      = 0;
      exp_q.push_back(e);
    end
    reset_n = 1'b1;
    wait_drain(6 * DECIMATION_FACTOR);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
